// File: rtl/id_stage_pkg.sv
// Shared DLX decode constants: opcodes, R-type/FP function codes and the
// ALU control encoding consumed by both the ID and EX stages.
package id_stage_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_FTYPE = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDUI = 6'h09;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_SUBUI = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LHI   = 6'h0F;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;
    localparam logic [5:0] OP_SLLI  = 6'h14;
    localparam logic [5:0] OP_SRLI  = 6'h16;
    localparam logic [5:0] OP_SRAI  = 6'h17;
    localparam logic [5:0] OP_SEQI  = 6'h18;
    localparam logic [5:0] OP_SGEI  = 6'h1D;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] F_SLL  = 6'h04;
    localparam logic [5:0] F_SRL  = 6'h06;
    localparam logic [5:0] F_SRA  = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_SEQ  = 6'h28;
    localparam logic [5:0] F_SGE  = 6'h2D;

    // FP-type function codes
    localparam logic [5:0] FF_MULT    = 6'h0E;
    localparam logic [5:0] FF_MULTU   = 6'h16;
    localparam logic [5:0] FF_MOVFP2I = 6'h34;
    localparam logic [5:0] FF_MOVI2FP = 6'h35;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_SEQ = 4'b1000,
        ALU_SNE = 4'b1001, ALU_SLT = 4'b1010, ALU_SGT = 4'b1011,
        ALU_SLE = 4'b1100, ALU_SGE = 4'b1101, ALU_LHI = 4'b1110
    } alu_ctrl_t;

    // The six set-ops are contiguous in both the R-type and I-type maps,
    // so the low three code bits select SEQ..SGE directly.
    function automatic alu_ctrl_t set_op_alu(input logic [2:0] sel);
        return alu_ctrl_t'(4'(ALU_SEQ) + {1'b0, sel});
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file with asynchronous clear, one write port that fires
// every clock and two combinational read ports with write-through.
// ZERO_R0 makes entry 0 a hard-wired zero (integer file).
module reg_file #(
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:4]  wr_addr,
    input  logic [0:31] wr_data,
    input  logic [0:4]  rd_addr_a,
    input  logic [0:4]  rd_addr_b,
    output logic [0:31] rd_data_a,
    output logic [0:31] rd_data_b
);

    logic [0:31] regs_reg [32];
    logic        wr_en;
    logic [0:4]  rd_addr [2];
    logic [0:31] rd_data [2];

    assign wr_en = !(ZERO_R0 && (wr_addr == 5'd0));

    // Storage: cleared while reset is high, otherwise written every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;
    assign rd_data_a  = rd_data[0];
    assign rd_data_b  = rd_data[1];

    // Read ports bypass the write data so ID sees this cycle's write-back
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rd_data[gi] = (!reset && wr_en && (rd_addr[gi] == wr_addr))
                                 ? wr_data : regs_reg[rd_addr[gi]];
        end
    endgenerate

endmodule

// File: rtl/id_stage.sv
// DLX instruction-decode stage: register files, operand selection,
// control decode and load-use hazard detection. Purely combinational
// apart from the register file storage.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] instruction,
    input  logic [0:31] BUS_W,
    input  logic [0:31] FBUS_W,
    input  logic [0:4]  Rw_ID_EX,
    input  logic [0:4]  Rw_EX_MEM,
    input  logic        LD_from_ID_EX,
    output logic [0:31] OPERAND_A,
    output logic [0:31] OPERAND_B,
    output logic [0:31] BUS_B,
    output logic [0:31] F_OPERAND_A,
    output logic [0:31] F_OPERAND_B,
    output logic        BRANCH,
    output logic        JUMP,
    output logic        FPU_CTRL_BITS,
    output logic        MEM_WR,
    output logic        MEM_TO_REG,
    output logic        MOV_INSTR,
    output logic        MEM_BYTE_OP,
    output logic        MEM_HALFWORD_OP,
    output logic        MEM_SIGN_EXT,
    output logic        JAL_INSTR,
    output logic        JUMP_USE_REG,
    output logic        Stall_ID,
    output logic [0:3]  ALU_CTRL_BITS
);

    logic [0:5]  opcode;
    logic [0:4]  rs;
    logic [0:4]  rt;
    logic [0:5]  func;
    logic [0:15] imm16;
    logic [0:25] off26;
    logic [0:31] int_b;
    alu_ctrl_t   alu;
    logic        rt_is_src;

    assign opcode = instruction[0:5];
    assign rs     = instruction[6:10];
    assign rt     = instruction[11:15];
    assign func   = instruction[26:31];
    assign imm16  = instruction[16:31];
    assign off26  = instruction[6:31];

    reg_file #(.ZERO_R0(1'b1)) u_int_rf (
        .clk(clk), .reset(reset),
        .wr_addr(Rw_EX_MEM), .wr_data(BUS_W),
        .rd_addr_a(rs), .rd_addr_b(rt),
        .rd_data_a(OPERAND_A), .rd_data_b(int_b)
    );

    reg_file #(.ZERO_R0(1'b0)) u_fp_rf (
        .clk(clk), .reset(reset),
        .wr_addr(Rw_EX_MEM), .wr_data(FBUS_W),
        .rd_addr_a(rs), .rd_addr_b(rt),
        .rd_data_a(F_OPERAND_A), .rd_data_b(F_OPERAND_B)
    );

    assign BUS_B         = int_b;
    assign ALU_CTRL_BITS = alu;

    // Second ALU operand: register, zero/sign-extended immediate or jump offset
    always_comb begin
        OPERAND_B = {{16{imm16[0]}}, imm16};
        case (opcode)
            OP_RTYPE:                             OPERAND_B = int_b;
            OP_ADDUI, OP_SUBUI,
            OP_ANDI, OP_ORI, OP_XORI:             OPERAND_B = {16'h0000, imm16};
            OP_J, OP_JAL:                         OPERAND_B = {{6{off26[0]}}, off26};
            default: ;
        endcase
    end

    // Control decode; anything unrecognised leaves every flag low and ALU at ADD
    always_comb begin
        alu             = ALU_ADD;
        BRANCH          = 1'b0;
        JUMP            = 1'b0;
        JUMP_USE_REG    = 1'b0;
        JAL_INSTR       = 1'b0;
        MEM_TO_REG      = 1'b0;
        MEM_WR          = 1'b0;
        MEM_BYTE_OP     = 1'b0;
        MEM_HALFWORD_OP = 1'b0;
        MEM_SIGN_EXT    = 1'b0;
        MOV_INSTR       = 1'b0;
        FPU_CTRL_BITS   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    F_SLL:         alu = ALU_SLL;
                    F_SRL:         alu = ALU_SRL;
                    F_SRA:         alu = ALU_SRA;
                    F_ADD, F_ADDU: alu = ALU_ADD;
                    F_SUB, F_SUBU: alu = ALU_SUB;
                    F_AND:         alu = ALU_AND;
                    F_OR:          alu = ALU_OR;
                    F_XOR:         alu = ALU_XOR;
                    default: begin
                        if (func >= F_SEQ && func <= F_SGE) alu = set_op_alu(func[3:5]);
                    end
                endcase
            end
            OP_FTYPE: begin
                case (func)
                    FF_MOVI2FP, FF_MOVFP2I: MOV_INSTR     = 1'b1;
                    FF_MULTU:               FPU_CTRL_BITS = 1'b1;
                    default: ;  // MULT and other FP ops keep FPU_CTRL_BITS low
                endcase
            end
            OP_J:               JUMP = 1'b1;
            OP_JAL:             begin JUMP = 1'b1; JAL_INSTR = 1'b1; end
            OP_JR:              begin JUMP = 1'b1; JUMP_USE_REG = 1'b1; end
            OP_JALR:            begin JUMP = 1'b1; JUMP_USE_REG = 1'b1; JAL_INSTR = 1'b1; end
            OP_BEQZ, OP_BNEZ:   BRANCH = 1'b1;
            OP_ADDI, OP_ADDUI:  alu = ALU_ADD;
            OP_SUBI, OP_SUBUI:  alu = ALU_SUB;
            OP_ANDI:            alu = ALU_AND;
            OP_ORI:             alu = ALU_OR;
            OP_XORI:            alu = ALU_XOR;
            OP_LHI:             alu = ALU_LHI;
            OP_SLLI:            alu = ALU_SLL;
            OP_SRLI:            alu = ALU_SRL;
            OP_SRAI:            alu = ALU_SRA;
            OP_LB:              begin MEM_TO_REG = 1'b1; MEM_BYTE_OP = 1'b1; MEM_SIGN_EXT = 1'b1; end
            OP_LH:              begin MEM_TO_REG = 1'b1; MEM_HALFWORD_OP = 1'b1; MEM_SIGN_EXT = 1'b1; end
            OP_LW:              MEM_TO_REG = 1'b1;
            OP_LBU:             begin MEM_TO_REG = 1'b1; MEM_BYTE_OP = 1'b1; end
            OP_LHU:             begin MEM_TO_REG = 1'b1; MEM_HALFWORD_OP = 1'b1; end
            OP_SB:              begin MEM_WR = 1'b1; MEM_BYTE_OP = 1'b1; end
            OP_SH:              begin MEM_WR = 1'b1; MEM_HALFWORD_OP = 1'b1; end
            OP_SW:              MEM_WR = 1'b1;
            default: begin
                if (opcode >= OP_SEQI && opcode <= OP_SGEI) alu = set_op_alu(opcode[3:5]);
            end
        endcase
    end

    // Load-use hazard: rt only matters when the instruction actually reads it
    always_comb begin
        rt_is_src = (opcode == OP_RTYPE) || (opcode == OP_FTYPE) ||
                    (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
        Stall_ID  = LD_from_ID_EX && (Rw_ID_EX != 5'd0) &&
                    ((Rw_ID_EX == rs) || (rt_is_src && (Rw_ID_EX == rt)));
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by randomized
// instructions/write-backs, all checked against a table-driven model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction, BUS_W, FBUS_W;
    logic [4:0]  Rw_ID_EX, Rw_EX_MEM;
    logic        LD_from_ID_EX;
    logic [31:0] OPERAND_A, OPERAND_B, BUS_B, F_OPERAND_A, F_OPERAND_B;
    logic        BRANCH, JUMP, FPU_CTRL_BITS, MEM_WR, MEM_TO_REG, MOV_INSTR;
    logic        MEM_BYTE_OP, MEM_HALFWORD_OP, MEM_SIGN_EXT, JAL_INSTR, JUMP_USE_REG, Stall_ID;
    logic [3:0]  ALU_CTRL_BITS;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .instruction(instruction), .BUS_W(BUS_W), .FBUS_W(FBUS_W),
        .Rw_ID_EX(Rw_ID_EX), .Rw_EX_MEM(Rw_EX_MEM), .LD_from_ID_EX(LD_from_ID_EX),
        .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .BUS_B(BUS_B),
        .F_OPERAND_A(F_OPERAND_A), .F_OPERAND_B(F_OPERAND_B),
        .BRANCH(BRANCH), .JUMP(JUMP), .FPU_CTRL_BITS(FPU_CTRL_BITS), .MEM_WR(MEM_WR),
        .MEM_TO_REG(MEM_TO_REG), .MOV_INSTR(MOV_INSTR), .MEM_BYTE_OP(MEM_BYTE_OP),
        .MEM_HALFWORD_OP(MEM_HALFWORD_OP), .MEM_SIGN_EXT(MEM_SIGN_EXT), .JAL_INSTR(JAL_INSTR),
        .JUMP_USE_REG(JUMP_USE_REG), .Stall_ID(Stall_ID), .ALU_CTRL_BITS(ALU_CTRL_BITS)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: register contents and ALU lookup tables
    logic [31:0] int_ref [32];
    logic [31:0] fp_ref  [32];
    logic [3:0]  alu_op_tab [64];
    logic [3:0]  alu_fn_tab [64];
    logic        pend;
    logic [31:0] pend_bw, pend_fbw;
    logic [4:0]  pend_rw;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rd_int(input logic [4:0] a);
        if (reset || a == 5'd0) return 32'd0;
        if (a == Rw_EX_MEM) return BUS_W;
        return int_ref[a];
    endfunction

    function automatic logic [31:0] rd_fp(input logic [4:0] a);
        if (reset) return 32'd0;
        if (a == Rw_EX_MEM) return FBUS_W;
        return fp_ref[a];
    endfunction

    function automatic logic [159:0] exp_data();
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic signed [15:0] s16;
        logic signed [25:0] s26;
        logic [31:0] opb;
        op  = instruction[31:26];
        rs  = instruction[25:21];
        rt  = instruction[20:16];
        s16 = instruction[15:0];
        s26 = instruction[25:0];
        if (op == 6'h00) opb = rd_int(rt);
        else if (op inside {6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E}) opb = {16'd0, instruction[15:0]};
        else if (op inside {6'h02, 6'h03}) opb = 32'(s26);
        else opb = 32'(s16);
        return {rd_int(rs), opb, rd_int(rt), rd_fp(rs), rd_fp(rt)};
    endfunction

    // {BRANCH,JUMP,JUMP_USE_REG,JAL,MEM_TO_REG,MEM_WR,BYTE,HALF,SEXT,MOV,FPU,STALL,ALU[3:0]}
    function automatic logic [15:0] exp_ctrl();
        logic [5:0] op, fn;
        logic [4:0] rs, rt;
        logic rt_src, stall;
        op = instruction[31:26];
        fn = instruction[5:0];
        rs = instruction[25:21];
        rt = instruction[20:16];
        rt_src = op inside {6'h00, 6'h01, 6'h28, 6'h29, 6'h2B};
        stall  = LD_from_ID_EX && Rw_ID_EX != 0 && (Rw_ID_EX == rs || (rt_src && Rw_ID_EX == rt));
        return {op inside {6'h04, 6'h05},
                op inside {6'h02, 6'h03, 6'h12, 6'h13},
                op inside {6'h12, 6'h13},
                op inside {6'h03, 6'h13},
                op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25},
                op inside {6'h28, 6'h29, 6'h2B},
                op inside {6'h20, 6'h24, 6'h28},
                op inside {6'h21, 6'h25, 6'h29},
                op inside {6'h20, 6'h21},
                op == 6'h01 && fn inside {6'h34, 6'h35},
                op == 6'h01 && fn == 6'h16,
                stall,
                (op == 6'h00) ? alu_fn_tab[fn] : alu_op_tab[op]};
    endfunction

    function automatic logic [15:0] obs_ctrl();
        return {BRANCH, JUMP, JUMP_USE_REG, JAL_INSTR, MEM_TO_REG, MEM_WR, MEM_BYTE_OP,
                MEM_HALFWORD_OP, MEM_SIGN_EXT, MOV_INSTR, FPU_CTRL_BITS, Stall_ID, ALU_CTRL_BITS};
    endfunction

    // One transaction: retire the previous write-back into the model, drive, compare
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] bw,
                        input logic [31:0] fbw, input logic [4:0] rwe, input logic [4:0] rwm,
                        input logic ld);
        @(negedge clk);
        if (pend) begin
            if (pend_rw != 0) int_ref[pend_rw] = pend_bw;
            fp_ref[pend_rw] = pend_fbw;
        end
        instruction = ins; BUS_W = bw; FBUS_W = fbw;
        Rw_ID_EX = rwe; Rw_EX_MEM = rwm; LD_from_ID_EX = ld;
        #1;
        check({tag, "_data"}, {OPERAND_A, OPERAND_B, BUS_B, F_OPERAND_A, F_OPERAND_B}, exp_data());
        check({tag, "_ctrl"}, 160'(obs_ctrl()), 160'(exp_ctrl()));
        $display("step %s ins=%h wb[%0d]=%h A=%h B=%h alu=%h stall=%b",
                 tag, ins, rwm, bw, OPERAND_A, OPERAND_B, ALU_CTRL_BITS, Stall_ID);
        pend = 1'b1; pend_bw = bw; pend_fbw = fbw; pend_rw = rwm;
    endtask

    int op_list[$] = '{'h00, 'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h08, 'h09, 'h0A, 'h0B,
                       'h0C, 'h0D, 'h0E, 'h0F, 'h12, 'h13, 'h14, 'h16, 'h17, 'h18, 'h19,
                       'h1A, 'h1B, 'h1C, 'h1D, 'h20, 'h21, 'h23, 'h24, 'h25, 'h28, 'h29, 'h2B};
    int fn_list[$] = '{'h04, 'h06, 'h07, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h28,
                       'h29, 'h2A, 'h2B, 'h2C, 'h2D, 'h0E, 'h16, 'h34, 'h35};

    initial begin
        logic [31:0] r, ins;
        logic [5:0]  op, fn;
        // ALU tables straight from the opcode/func map; unlisted entries mean ADD
        for (int i = 0; i < 64; i++) begin alu_op_tab[i] = 4'd0; alu_fn_tab[i] = 4'd0; end
        alu_fn_tab['h04] = 5; alu_fn_tab['h06] = 6; alu_fn_tab['h07] = 7;
        alu_fn_tab['h22] = 1; alu_fn_tab['h23] = 1; alu_fn_tab['h24] = 2;
        alu_fn_tab['h25] = 3; alu_fn_tab['h26] = 4;
        alu_op_tab['h0A] = 1; alu_op_tab['h0B] = 1; alu_op_tab['h0C] = 2;
        alu_op_tab['h0D] = 3; alu_op_tab['h0E] = 4; alu_op_tab['h0F] = 14;
        alu_op_tab['h14] = 5; alu_op_tab['h16] = 6; alu_op_tab['h17] = 7;
        for (int k = 0; k < 6; k++) begin
            alu_fn_tab['h28 + k] = 4'(8 + k);
            alu_op_tab['h18 + k] = 4'(8 + k);
        end
        for (int i = 0; i < 32; i++) begin int_ref[i] = 0; fp_ref[i] = 0; end
        pend = 1'b0; pend_bw = 0; pend_fbw = 0; pend_rw = 0;

        reset = 1'b1; instruction = 0; BUS_W = 0; FBUS_W = 0;
        Rw_ID_EX = 0; Rw_EX_MEM = 0; LD_from_ID_EX = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Reset state with ADD r3,r1,r2
        step("add_rst", 32'h00221820, 0, 0, 0, 0, 0);
        check("rst_alu", 160'(ALU_CTRL_BITS), 160'(4'b0000));
        check("rst_opa", 160'(OPERAND_A), 160'(32'd0));
        check("rst_opb", 160'(OPERAND_B), 160'(32'd0));
        check("rst_stall", 160'(Stall_ID), 160'(1'b0));

        // Write r1=5 (visible through write-through), then read it back stored
        step("wr_r1", 32'h00221820, 32'h5, 32'h3F800000, 0, 1, 0);
        check("wt_opa", 160'(OPERAND_A), 160'(32'h5));
        step("rd_r1", 32'h00221820, 32'hFFFFFFFF, 0, 0, 0, 0);
        check("stored_opa", 160'(OPERAND_A), 160'(32'h5));

        // Load-use hazard on rs, then no match
        step("haz_hit", 32'h00221820, 32'hFFFFFFFF, 0, 1, 0, 1);
        check("stall_rs", 160'(Stall_ID), 160'(1'b1));
        step("haz_miss", 32'h00221820, 32'hFFFFFFFF, 0, 4, 0, 1);
        check("stall_none", 160'(Stall_ID), 160'(1'b0));

        // Zero instruction: R0 ignored write, all controls low
        step("nop", 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0);
        check("r0_zero", 160'(OPERAND_A), 160'(32'd0));
        check("nop_ctrl", 160'(obs_ctrl()), 160'(16'd0));

        // LW r2,-4(r1)
        step("lw", 32'h8C22FFFC, 0, 0, 0, 7, 0);
        check("lw_m2r", 160'(MEM_TO_REG), 160'(1'b1));
        check("lw_opb", 160'(OPERAND_B), 160'(32'hFFFFFFFC));
        check("lw_sext", 160'(MEM_SIGN_EXT), 160'(1'b0));
        check("lw_alu", 160'(ALU_CTRL_BITS), 160'(4'b0000));

        // JALR r1 and BEQZ
        step("jalr", 32'h4C200000, 0, 0, 0, 7, 0);
        check("jalr_flags", 160'({JUMP, JUMP_USE_REG, JAL_INSTR}), 160'(3'b111));
        step("beqz", 32'h1020000C, 0, 0, 0, 7, 0);
        check("beqz_br", 160'(BRANCH), 160'(1'b1));
        check("beqz_opb", 160'(OPERAND_B), 160'(32'h0000000C));

        // Asynchronous reset in mid-cycle clears reads immediately
        step("pre_rst", 32'h00221820, 0, 0, 0, 7, 0);
        check("pre_rst_opa", 160'(OPERAND_A), 160'(32'h5));
        reset = 1'b1;
        #1;
        check("async_rst_opa", 160'(OPERAND_A), 160'(32'd0));
        check("async_rst_fopa", 160'(F_OPERAND_A), 160'(32'd0));
        for (int i = 0; i < 32; i++) begin int_ref[i] = 0; fp_ref[i] = 0; end
        pend = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 300; n++) begin
            r  = $urandom();
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom()) : 6'(op_list[$urandom_range(0, op_list.size() - 1)]);
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'(fn_list[$urandom_range(0, fn_list.size() - 1)]);
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[15:0]};
            if (op <= 6'h01) ins[5:0] = fn;
            step($sformatf("rnd%0d", n), ins, $urandom(), $urandom(),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-high reset.
REQ-002 SHALL have inputs: instruction [0:31] (bit 0 = MSB); BUS_W [0:31] integer write-back data; FBUS_W [0:31] FP write-back data.
REQ-003 SHALL have inputs: Rw_ID_EX [0:4], destination of the instruction in EX; Rw_EX_MEM [0:4], write-back register index; LD_from_ID_EX 1, the EX instruction is a load.
REQ-004 SHALL have 32-bit outputs: OPERAND_A, OPERAND_B, BUS_B, F_OPERAND_A, F_OPERAND_B.
REQ-005 SHALL have 1-bit outputs BRANCH, JUMP, FPU_CTRL_BITS, MEM_WR, MEM_TO_REG, MOV_INSTR, MEM_BYTE_OP, MEM_HALFWORD_OP, MEM_SIGN_EXT, JAL_INSTR, JUMP_USE_REG, Stall_ID, and output ALU_CTRL_BITS [0:3].

Function
REQ-006 SHALL decode DLX fields: opcode [0:5], rs [6:10], rt [11:15], rd [16:20], func [26:31], imm16 [16:31], off26 [6:31].
REQ-007 SHALL hold 32x32 integer and 32x32 FP register files; integer R0 reads 0 and is never written.
REQ-008 On each rising clk, SHALL write BUS_W to int[Rw_EX_MEM] (if index != 0) and FBUS_W to fp[Rw_EX_MEM].
REQ-009 Reads SHALL be combinational with write-through: a read of the index being written this cycle returns the write data.
REQ-010 OPERAND_A = int[rs]; BUS_B = int[rt]; F_OPERAND_A = fp[rs]; F_OPERAND_B = fp[rt].
REQ-011 OPERAND_B SHALL be int[rt] for opcode 0x00; zero-extended imm16 for ANDI/ORI/XORI (0x0C-0x0E) and ADDUI/SUBUI (0x09, 0x0B); sign-extended off26 for J/JAL (0x02/0x03); sign-extended imm16 otherwise.
REQ-012 ALU_CTRL_BITS encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SEQ, 1001 SNE, 1010 SLT, 1011 SGT, 1100 SLE, 1101 SGE, 1110 LHI (B<<16).
REQ-013 R-type func map: 0x04 SLL, 0x06 SRL, 0x07 SRA, 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x28-0x2D SEQ..SGE; I-type analogues likewise (0x08/0x09 ADD, 0x0A/0x0B SUB, 0x14/0x16/0x17 shifts, 0x18-0x1D set-ops, 0x0F LHI); loads, stores, branches, jumps use ADD; unknown opcodes give ADD with all control bits 0.
REQ-014 BRANCH=1 for BEQZ/BNEZ (0x04/0x05); JUMP=1 for 0x02, 0x03, 0x12, 0x13; JUMP_USE_REG=1 for JR/JALR (0x12/0x13); JAL_INSTR=1 for JAL/JALR.
REQ-015 MEM_TO_REG=1 for loads 0x20,0x21,0x23,0x24,0x25; MEM_WR=1 for stores 0x28,0x29,0x2B.
REQ-016 MEM_BYTE_OP=1 for LB/LBU/SB; MEM_HALFWORD_OP=1 for LH/LHU/SH; MEM_SIGN_EXT=1 for LB/LH only.
REQ-017 For opcode 0x01: MOV_INSTR=1 for MOVI2FP/MOVFP2I (func 0x35/0x34); FPU_CTRL_BITS=1 for MULTU (func 0x16), 0 for MULT (0x0E) and all else.
REQ-018 Stall_ID=1 iff LD_from_ID_EX=1, Rw_ID_EX!=0 and Rw_ID_EX equals rs, or equals rt when rt is a source (R-type, stores, FP ops); else 0.
REQ-019 All outputs SHALL be combinational from instruction, register contents and hazard inputs; zero latency.
REQ-020 Simultaneous write and read of the same register SHALL follow REQ-009; writes to R0 SHALL be ignored.

Reset
REQ-021 reset high SHALL asynchronously clear all 64 registers to 0 and block writes while asserted.
REQ-022 Decode outputs SHALL not depend on reset; with instruction = 0 all control bits are 0 and ALU_CTRL_BITS=0000.

Structure
REQ-023 Opcode/func constants and ALU_CTRL encodings SHALL live in a shared package used by ID and EX.
REQ-024 A single sub-module reg_file (32x32, async reset, write-through read) SHALL be instantiated twice (integer, FP).

Verification
REQ-025 Reset then instruction 0x00221820 (ADD r3,r1,r2), LD_from_ID_EX=0 -> ALU_CTRL_BITS=0000, OPERAND_A=0, OPERAND_B=0, Stall_ID=0.
REQ-026 Write BUS_W=0x00000005 with Rw_EX_MEM=1, then 0x00221820 -> OPERAND_A=0x00000005.
REQ-027 0x00221820, Rw_ID_EX=1, LD_from_ID_EX=1 -> Stall_ID=1; Rw_ID_EX=4 -> Stall_ID=0.
REQ-028 LW r2,-4(r1) (0x8C22FFFC) -> MEM_TO_REG=1, OPERAND_B=0xFFFFFFFC, MEM_SIGN_EXT=0, ALU ADD.
REQ-029 JALR r1 (0x4C200000) -> JUMP=1, JUMP_USE_REG=1, JAL_INSTR=1; BEQZ (0x1020000C) -> BRANCH=1, OPERAND_B=0x0000000C.
REQ-030 Write with Rw_EX_MEM=0, BUS_W=0xFFFFFFFF -> OPERAND_A for rs=0 stays 0; async reset mid-run clears read values to 0 immediately.
